// File: rtl/resize_mac_accum_if.sv
// rtl/resize_mac_accum_if.sv - valid/ready stream bundle shared by product input and pixel output
interface resize_mac_accum_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/resize_mac_accum.sv
// rtl/resize_mac_accum.sv - sums NUM_TAPS signed products per pixel, rounds, clamps to 8 bits
module resize_mac_accum #(
  parameter int NUM_TAPS   = 4,
  parameter int PROD_WIDTH = 28,
  parameter int FRAC_BITS  = 12,
  parameter int ACC_WIDTH  = PROD_WIDTH + 4
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  resize_mac_accum_if.slave  prod,
  resize_mac_accum_if.master pix,
  output logic [15:0]        sat_cnt
);

  localparam int TW = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'(255);

  logic [TW-1:0]                tap_cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  r;
  logic                         last_tap;
  logic                         accept;
  logic                         clamped;
  logic [7:0]                   pix_next;
  logic [7:0]                   pix_tdata_q;
  logic                         pix_tlast_q;
  logic                         pix_tvalid_q;

  assign last_tap    = (tap_cnt == LAST_TAP);
  // Only the final tap produces a pixel, so only it can be back-pressured.
  assign prod.tready = !last_tap || !pix_tvalid_q || pix.tready;
  assign accept      = prod.tvalid && prod.tready;

  assign pix.tdata  = pix_tdata_q;
  assign pix.tlast  = pix_tlast_q;
  assign pix.tvalid = pix_tvalid_q;

  always_comb begin
    prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod.tdata[PROD_WIDTH-1]}}, prod.tdata};
    sum      = acc + prod_ext;
    r        = (sum + HALF) >>> FRAC_BITS;
    clamped  = 1'b0;
    pix_next = r[7:0];
    if (r[ACC_WIDTH-1]) begin
      clamped  = 1'b1;
      pix_next = 8'd0;
    end else if (r > PIX_MAX) begin
      clamped  = 1'b1;
      pix_next = 8'd255;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tap_cnt      <= '0;
      acc          <= '0;
      pix_tdata_q  <= '0;
      pix_tlast_q  <= 1'b0;
      pix_tvalid_q <= 1'b0;
      sat_cnt      <= '0;
    end else begin
      if (accept) begin
        tap_cnt <= last_tap ? '0 : tap_cnt + TW'(1);
        acc     <= (tap_cnt == '0) ? prod_ext : sum;
      end

      if (accept && last_tap) begin
        pix_tdata_q  <= pix_next;
        pix_tlast_q  <= prod.tlast;
        pix_tvalid_q <= 1'b1;
        if (clamped && sat_cnt != 16'hFFFF) begin
          sat_cnt <= sat_cnt + 16'd1;
        end
      end else if (pix_tvalid_q && pix.tready) begin
        pix_tvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resize_mac_accum.sv
// tb/tb_resize_mac_accum.sv - scoreboard bench: driver pushes expected pixels, negedge monitor checks
module tb_resize_mac_accum;

  localparam int N  = 4;
  localparam int PW = 28;
  localparam int FB = 12;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [15:0] sat_cnt;

  always #5 ap_clk = ~ap_clk;

  resize_mac_accum_if #(.W(PW)) prod_if ();
  resize_mac_accum_if #(.W(8))  pix_if ();

  resize_mac_accum #(
    .NUM_TAPS  (N),
    .PROD_WIDTH(PW),
    .FRAC_BITS (FB),
    .ACC_WIDTH (PW + 4)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .prod    (prod_if),
    .pix     (pix_if),
    .sat_cnt (sat_cnt)
  );

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [15:0] sat;
  } exp_t;

  exp_t   exp_q[$];
  longint m_taps[$];
  logic   m_lasts[$];
  int     m_sat = 0;
  int     rdy_mode = 0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: a pixel is the rounded, clamped Q-format sum of its N taps.
  task automatic model_accept(input longint d, input logic l);
    longint s;
    longint q;
    exp_t   e;
    m_taps.push_back(d);
    m_lasts.push_back(l);
    if (m_taps.size() == N) begin
      s = 0;
      foreach (m_taps[i]) s += m_taps[i];
      q = (s + (longint'(1) << (FB - 1))) >>> FB;
      if (q < 0 || q > 255) begin
        if (m_sat < 65535) m_sat++;
        q = (q < 0) ? 0 : 255;
      end
      e.data = 8'(q);
      e.last = m_lasts[N-1];
      e.sat  = 16'(m_sat);
      exp_q.push_back(e);
      m_taps.delete();
      m_lasts.delete();
    end
  endtask

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_beat(input longint d, input logic l);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      @(posedge ap_clk); #2;
      prod_if.tvalid = 1'b1;
      prod_if.tdata  = PW'(d);
      prod_if.tlast  = l;
      pix_if.tready  = pick_rdy();
      #1;
      if (prod_if.tready) begin
        model_accept(d, l);
        done = 1;
      end else if (++guard > 200) begin
        chk("beat_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk); #2;
      prod_if.tvalid = 1'b0;
      prod_if.tlast  = 1'b0;
      pix_if.tready  = pick_rdy();
    end
  endtask

  task automatic send_group(input longint d0, input longint d1, input longint d2,
                            input longint d3, input logic [3:0] lasts);
    send_beat(d0, lasts[0]);
    send_beat(d1, lasts[1]);
    send_beat(d2, lasts[2]);
    send_beat(d3, lasts[3]);
  endtask

  task automatic drain();
    int guard = 0;
    rdy_mode = 0;
    idle(1);
    while (exp_q.size() != 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    idle(2);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor state
  int         mon_beat = 0;
  bit         final_prev = 0;
  bit         hold_prev = 0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst_n) begin
      mon_beat   = 0;
      final_prev = 0;
      hold_prev  = 0;
    end else begin
      if (final_prev) chk("latency_valid", pix_if.tvalid, 1);
      if (hold_prev) begin
        chk("hold_valid", pix_if.tvalid, 1);
        chk("hold_data", pix_if.tdata, hold_data);
        chk("hold_last", pix_if.tlast, hold_last);
      end
      if (pix_if.tvalid && pix_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", pix_if.tdata, e.data);
          chk("pix_last", pix_if.tlast, e.last);
          chk("sat_cnt", sat_cnt, e.sat);
        end
      end
      hold_prev = pix_if.tvalid && !pix_if.tready;
      hold_data = pix_if.tdata;
      hold_last = pix_if.tlast;
      final_prev = 0;
      if (prod_if.tvalid && prod_if.tready) begin
        mon_beat = (mon_beat + 1) % N;
        final_prev = (mon_beat == 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, pix_if.tvalid, 0);
    chk({tag, "_tdata"}, pix_if.tdata, 0);
    chk({tag, "_tlast"}, pix_if.tlast, 0);
    chk({tag, "_sat"}, sat_cnt, 0);
    chk({tag, "_prod_tready"}, prod_if.tready, 1);
  endtask

  initial begin
    logic signed [PW-1:0] v;
    longint d[4];
    logic [3:0] ls;

    prod_if.tvalid = 1'b0;
    prod_if.tdata  = '0;
    prod_if.tlast  = 1'b0;
    pix_if.tready  = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;

    // Nominal, rounding and clamp groups
    rdy_mode = 0;
    send_group(102400, 102400, 102400, 102400, 4'b0000);
    send_group(102912, 102912, 102912, 102912, 4'b0000);
    send_group(102400, 102400, 102400, 102399, 4'b0000);
    send_group(-1250, -1250, -1250, -1250, 4'b0000);
    send_group(300000, 300000, 300000, 300000, 4'b0000);
    // tlast only honoured on the final tap
    send_group(102400, 102400, 102400, 102400, 4'b0010);
    send_group(204800, 204800, 204800, 204800, 4'b1000);
    drain();

    // Output back-pressure stalls only the final tap
    rdy_mode = 2;
    send_group(51200, 51200, 51200, 51200, 4'b0000);
    send_beat(204800, 1'b0);
    send_beat(204800, 1'b0);
    send_beat(204800, 1'b0);
    repeat (3) begin
      @(posedge ap_clk); #2;
      prod_if.tvalid = 1'b1;
      prod_if.tdata  = PW'(204800);
      prod_if.tlast  = 1'b1;
      pix_if.tready  = 1'b0;
      #1;
      chk("stall_tready", prod_if.tready, 0);
      chk("stall_data", pix_if.tdata, 50);
    end
    @(posedge ap_clk); #2;
    pix_if.tready = 1'b1;
    #1;
    chk("release_tready", prod_if.tready, 1);
    if (prod_if.tready) model_accept(204800, 1'b1);
    drain();

    // Reset in mid-group discards the partial sum
    send_beat(204800, 1'b0);
    send_beat(204800, 1'b0);
    send_beat(204800, 1'b0);
    @(posedge ap_clk); #2;
    prod_if.tvalid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_taps.delete();
    m_lasts.delete();
    m_sat = 0;
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    send_group(102400, 102400, 102400, 102400, 4'b0000);
    drain();

    // Randomised groups with random gaps and back-pressure
    rdy_mode = 1;
    repeat (60) begin
      for (int t = 0; t < 4; t++) begin
        if ($urandom_range(0, 9) == 0) begin
          v = PW'($urandom);
          d[t] = v;
        end else begin
          d[t] = longint'($urandom_range(0, 330000)) - 30000;
        end
        ls[t] = 1'($urandom_range(0, 1));
      end
      for (int t = 0; t < 4; t++) begin
        send_beat(d[t], ls[t]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/resize_mac_accum.md
RESIZE_MAC_ACCUM -- requirements
Module: resize_mac_accum

Interface
REQ-001 SHALL provide parameter NUM_TAPS, default 4, products summed per output pixel (2..16).
REQ-002 SHALL provide parameter PROD_WIDTH, default 28, signed product width from the coefficient x pixel multiplier.
REQ-003 SHALL provide parameter FRAC_BITS, default 12, fractional bits of coefficients (unity weight = 2^FRAC_BITS).
REQ-004 SHALL provide parameter ACC_WIDTH, default PROD_WIDTH+4, signed accumulator width.
REQ-005 ap_clk  in  1  single clock; all state on rising edge.
REQ-006 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 prod_tdata  in  PROD_WIDTH  signed product, one tap per beat.
REQ-008 prod_tvalid  in  1  product beat valid.
REQ-009 prod_tready  out  1  product beat accepted when tvalid and tready are both high.
REQ-010 prod_tlast  in  1  end-of-line marker; sampled only on the final tap of a group.
REQ-011 pix_tdata  out  8  rounded, clamped output pixel.
REQ-012 pix_tvalid  out  1  output pixel valid.
REQ-013 pix_tready  in  1  downstream ready.
REQ-014 pix_tlast  out  1  end-of-line, qualified by pix_tvalid.
REQ-015 sat_cnt  out  16  count of clamped output pixels.

Function
REQ-016 SHALL keep tap counter tap_cnt (0..NUM_TAPS-1), incremented per accepted beat, wrapping to 0 after tap NUM_TAPS-1.
REQ-017 SHALL on an accepted beat with tap_cnt=0 load acc <= sign-extended prod_tdata, discarding the prior sum.
REQ-018 SHALL on an accepted beat with tap_cnt>0 update acc <= acc + sign-extended prod_tdata; no overflow handling within ACC_WIDTH.
REQ-019 SHALL on the final tap form sum = acc + prod_tdata, then r = (sum + 2^(FRAC_BITS-1)) arithmetically shifted right by FRAC_BITS.
REQ-020 SHALL clamp r: r<0 -> 0, r>255 -> 255, else r[7:0]; either clamp increments sat_cnt.
REQ-021 SHALL register the clamped value into pix_tdata and prod_tlast into pix_tlast, with pix_tvalid=1 on the cycle after the final tap is accepted (latency 1).
REQ-022 SHALL hold pix_tdata/pix_tlast/pix_tvalid stable while pix_tvalid=1 and pix_tready=0.
REQ-023 SHALL clear pix_tvalid after a pix handshake unless a new final tap is accepted in the same cycle, in which case pix_tvalid stays 1 with new data.
REQ-024 SHALL drive prod_tready = (tap_cnt != NUM_TAPS-1) OR NOT pix_tvalid OR pix_tready; non-final taps are never stalled by the output.
REQ-025 SHALL sustain one accepted tap per cycle, i.e. one pixel per NUM_TAPS cycles with pix_tready held high.
REQ-026 SHALL saturate sat_cnt at 0xFFFF without wrapping.
REQ-027 SHALL ignore prod_tlast on non-final taps and SHALL NOT realign tap_cnt on it.
REQ-028 SHALL leave acc, tap_cnt and outputs unchanged on cycles with no accepted beat.

Reset
REQ-029 SHALL on ap_rst_n=0, independent of clock, clear tap_cnt, acc, pix_tdata, pix_tlast, pix_tvalid and sat_cnt to 0.
REQ-030 SHALL discard a partially accumulated group on reset; the first beat after release is tap 0.
REQ-031 SHALL keep prod_tready=1 during and after reset (tap_cnt=0, pix_tvalid=0).

Verification
REQ-032 Four taps of 102400 (0.25x100), ready high -> pix_tdata=100 one cycle after fourth tap, sat_cnt=0.
REQ-033 Taps summing to 411648 (100.5 in Q12) -> pix_tdata=101 (round half up); sum 409599 -> 100.
REQ-034 Taps summing to -5000 -> pix_tdata=0, sat_cnt=1; then taps summing to 1200000 -> pix_tdata=255, sat_cnt=2.
REQ-035 pix_tready=0 with pixel held: next group's taps 0-2 accepted, tap 3 stalls (prod_tready=0), pix_tdata unchanged; pix_tready=1 -> tap 3 accepted same cycle, new pixel next cycle.
REQ-036 ap_rst_n pulsed low after tap 2 of a group -> all outputs 0; four taps of 102400 after release -> pix_tdata=100.
REQ-037 prod_tlast=1 on tap 1 only, then on tap 3 of the next group -> first pixel pix_tlast=0, second pixel pix_tlast=1.
